calc_seq_fsm: RTL and testbench

Parametrised keypad-to-arithmetic sequencer. It is the next-generation replacement for the calculator's inline entry logic.
- Buffers extended-BCD key events in a FIFO and assembles signed decimal operands of configurable digit count.
- Selects operators and drives a start/done handshake to the arithmetic unit (calculate).
- Exports display value and mode to the segment driver path.

---
 rtl/calc_seq_fsm.sv | 250 +++++++++++++++++++++++++
 tb/tb_calc_seq_fsm.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_fsm.sv
// calc_seq_fsm: keypad FIFO, signed operand entry and start/done handshake to the arithmetic unit.
// Optional macro CALC_CHAIN_EN: operator keys in the second operand launch the calculation and chain on.
module calc_seq_fsm #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DIGITS     = 6,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             sw_clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             calc_start,
  input  logic             calc_done,
  input  logic             calc_err,
  input  logic [WIDTH-1:0] calc_ans,
  output logic [WIDTH-1:0] operand1,
  output logic [WIDTH-1:0] operand2,
  output logic [2:0]       operator,
  output logic [WIDTH-1:0] disp_value,
  output logic [2:0]       disp_mode,
  output logic             fifo_ovf
);
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PW + 1;
  localparam int unsigned CW    = $clog2(DIGITS + 1);

  localparam logic [2:0] OP_EQU   = 3'd0;
  localparam logic [2:0] OP_TIMES = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_PLUS  = 3'd3;
  localparam logic [2:0] OP_MINUS = 3'd4;
  localparam logic [2:0] OP_MOD   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_OPND1, S_OPND2, S_OPR, S_CALC, S_RESULT, S_ERROR
  } state_t;

  state_t            state;
  logic [3:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              full, push, pop, has_key;
  logic [3:0]        head;
  logic              is_digit, k_a, k_b, k_c, k_d, k_e, k_f, chain_key_c;
  logic [WIDTH-1:0]  mag, ans, x_c, mag_dig_c;
  logic              sign, locked;
  logic [CW-1:0]     cnt, lim_c;
`ifdef CALC_CHAIN_EN
  logic              chain;
`endif

  assign full     = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign has_key  = (fifo_cnt != '0);
  assign push     = key_valid && (!full || pop);
  assign head     = fifo_mem[rd_ptr];
  assign is_digit = (head <= 4'd9);
  assign k_a      = (head == 4'hA);
  assign k_b      = (head == 4'hB);
  assign k_c      = (head == 4'hC);
  assign k_d      = (head == 4'hD);
  assign k_e      = (head == 4'hE);
  assign k_f      = (head == 4'hF);
  assign chain_key_c = k_a || k_b || (k_c && (cnt != '0));

  // Signed view of the operand being entered; a negative entry has one digit less
  assign x_c       = sign ? -mag : mag;
  assign lim_c     = sign ? CW'(DIGITS - 1) : CW'(DIGITS);
  assign mag_dig_c = (mag << 3) + (mag << 1) + WIDTH'(head);

  // Pop decision: keys that trigger a state change without being consumed stay at the head
  always_comb begin
    pop = 1'b0;
    if (has_key) begin
      case (state)
        S_OPND1:  pop = !chain_key_c;
`ifdef CALC_CHAIN_EN
        S_OPND2:  pop = !chain_key_c;
`else
        S_OPND2:  pop = 1'b1;
`endif
        S_OPR:    pop = !(is_digit || k_e);
        S_RESULT: pop = k_f || k_d;
        S_ERROR:  pop = 1'b1;
        default:  pop = 1'b0;
      endcase
    end
  end

  // Key FIFO; a push into a full FIFO succeeds only when the head leaves the same cycle
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      fifo_ovf <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[PW'(i)] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= key_code;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_W'(1);
      if (key_valid && !push) fifo_ovf <= 1'b1;
    end
  end

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      calc_start <= 1'b0;
      operand1   <= '0;
      operand2   <= '0;
      operator   <= OP_EQU;
      disp_value <= '0;
      disp_mode  <= 3'd4;
      mag        <= '0;
      ans        <= '0;
      sign       <= 1'b0;
      locked     <= 1'b0;
      cnt        <= '0;
`ifdef CALC_CHAIN_EN
      chain      <= 1'b0;
`endif
    end else begin
      calc_start <= 1'b0;
      case (state)
        S_IDLE: begin
          disp_mode  <= 3'd4;
          disp_value <= '0;
          if (has_key) begin
            operand1  <= '0;
            operand2  <= '0;
            operator  <= OP_EQU;
            mag       <= '0;
            sign      <= 1'b0;
            locked    <= 1'b0;
            cnt       <= '0;
            disp_mode <= 3'd0;
            state     <= S_OPND1;
          end
        end

        S_OPND1, S_OPND2: begin
          if (state == S_OPND1) operand1 <= x_c;
          else                  operand2 <= x_c;
          disp_value <= x_c;
          disp_mode  <= locked ? 3'd2 : 3'd0;
          if (has_key) begin
            if (is_digit) begin
              if (!locked && (cnt < lim_c)) begin
                mag <= mag_dig_c;
                cnt <= cnt + CW'(1);
              end
            end else if (k_c && (cnt == '0)) begin
              sign <= !sign;
            end else if (k_e) begin
              mag       <= ans;
              locked    <= 1'b1;
              disp_mode <= 3'd2;
            end else if (k_d) begin
              mag    <= '0;
              sign   <= 1'b0;
              cnt    <= '0;
              locked <= 1'b0;
            end else if (k_f) begin
              if (state == S_OPND1) begin
                ans   <= x_c;
                state <= S_RESULT;
              end else begin
                calc_start <= 1'b1;
                state      <= S_CALC;
              end
            end else if (state == S_OPND1) begin
              operator <= OP_EQU;
              state    <= S_OPR;
            end else begin
`ifdef CALC_CHAIN_EN
              chain      <= 1'b1;
              calc_start <= 1'b1;
              state      <= S_CALC;
`endif
            end
          end
        end

        S_OPR: begin
          disp_mode  <= 3'd1;
          disp_value <= WIDTH'(operator);
          if (has_key) begin
            if (k_a)      operator <= (operator == OP_DIV) ? OP_MOD : OP_DIV;
            else if (k_b) operator <= OP_TIMES;
            else if (k_c) operator <= (operator == OP_PLUS) ? OP_MINUS : OP_PLUS;
            else if (is_digit || k_e) begin
              mag    <= '0;
              sign   <= 1'b0;
              cnt    <= '0;
              locked <= 1'b0;
              state  <= S_OPND2;
            end
          end
        end

        S_CALC: begin
          if (calc_done) begin
            if (calc_err) begin
              state <= S_ERROR;
            end else begin
              ans   <= calc_ans;
              state <= S_RESULT;
`ifdef CALC_CHAIN_EN
              if (chain) begin
                operand1 <= calc_ans;
                operator <= OP_EQU;
                state    <= S_OPR;
              end
`endif
            end
`ifdef CALC_CHAIN_EN
            chain <= 1'b0;
`endif
          end
        end

        S_RESULT: begin
          disp_value <= ans;
          disp_mode  <= 3'd0;
          if (has_key) begin
            if (is_digit || k_c || k_e || k_d) begin
              state <= S_IDLE;
            end else if (k_a || k_b) begin
              operand1 <= ans;
              operator <= OP_EQU;
              state    <= S_OPR;
            end
          end
        end

        S_ERROR: begin
          disp_mode <= 3'd3;
          if (has_key && k_d) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq_fsm.sv
// tb_calc_seq_fsm: directed and random keypad traffic checked against a key-level reference model.
module tb_calc_seq_fsm;
  localparam int WIDTH      = 32;
  localparam int DIGITS     = 6;
  localparam int FIFO_DEPTH = 8;
`ifdef CALC_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic             sw_clk, rst, key_valid, calc_start, calc_done, calc_err, fifo_ovf;
  logic [3:0]       key_code;
  logic [WIDTH-1:0] calc_ans, operand1, operand2, disp_value;
  logic [2:0]       operator, disp_mode;

  calc_seq_fsm #(.WIDTH(WIDTH), .DIGITS(DIGITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .sw_clk(sw_clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .calc_start(calc_start), .calc_done(calc_done), .calc_err(calc_err), .calc_ans(calc_ans),
    .operand1(operand1), .operand2(operand2), .operator(operator),
    .disp_value(disp_value), .disp_mode(disp_mode), .fifo_ovf(fifo_ovf)
  );

  initial sw_clk = 1'b0;
  always #5 sw_clk = ~sw_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Key-level reference model: one call per key, arithmetic on plain integers
  typedef enum {M_IDLE, M_OP1, M_OP2, M_OPR, M_RES, M_ERR} mst_t;
  typedef struct {
    int     a;
    int     b;
    int     op;
    longint r;
    bit     err;
  } txn_t;

  mst_t m_st;
  int   m_op1, m_op2, m_opr, m_ans, m_mag, m_cnt;
  bit   m_sgn, m_lock;
  bit   rand_err = 1'b0;
  bit   hold = 1'b0;
  txn_t exp_q[$];

  function automatic int mval();
    return m_sgn ? -m_mag : m_mag;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_op1 = 0; m_op2 = 0; m_opr = 0; m_ans = 0;
    m_mag = 0; m_cnt = 0; m_sgn = 0; m_lock = 0;
    exp_q.delete();
  endtask

  task automatic do_calc(input bit chained);
    longint a, b, r;
    bit e;
    a = m_op1; b = m_op2; r = 0; e = 0;
    case (m_opr)
      1: r = a * b;
      2: if (b == 0) e = 1; else r = a / b;
      3: r = a + b;
      4: r = a - b;
      5: if (b == 0) e = 1; else r = a % b;
      default: r = b;
    endcase
    if (r > 64'sd2147483647 || r < -64'sd2147483648) e = 1;
    if (rand_err && $urandom_range(0, 9) == 0) e = 1;
    if (e) r = 0;
    exp_q.push_back('{a: m_op1, b: m_op2, op: m_opr, r: r, err: e});
    if (e) m_st = M_ERR;
    else begin
      m_ans = int'(r);
      if (chained) begin m_op1 = int'(r); m_opr = 0; m_st = M_OPR; end
      else m_st = M_RES;
    end
  endtask

  task automatic model_key(input int k);
    bit used, dig;
    used = 0;
    dig  = (k <= 9);
    for (int guard = 0; guard < 8 && !used; guard++) begin
      case (m_st)
        M_IDLE: begin
          m_op1 = 0; m_op2 = 0; m_opr = 0; m_mag = 0; m_cnt = 0; m_sgn = 0; m_lock = 0;
          m_st = M_OP1;
        end
        M_OP1, M_OP2: begin
          used = 1;
          if (dig) begin
            if (!m_lock && m_cnt < (m_sgn ? DIGITS - 1 : DIGITS)) begin
              m_mag = m_mag * 10 + k; m_cnt++;
            end
          end else if (k == 12 && m_cnt == 0) m_sgn = !m_sgn;
          else if (k == 14) begin m_mag = m_ans; m_lock = 1; end
          else if (k == 13) begin m_mag = 0; m_sgn = 0; m_cnt = 0; m_lock = 0; end
          else if (k == 15) begin
            if (m_st == M_OP1) begin m_ans = mval(); m_st = M_RES; end
            else begin m_op2 = mval(); do_calc(0); end
          end else if (m_st == M_OP1) begin
            m_op1 = mval(); m_opr = 0; m_st = M_OPR; used = 0;
          end else if (CHAIN) begin
            m_op2 = mval(); do_calc(1); used = 0;
          end
        end
        M_OPR: begin
          used = 1;
          if (k == 10) m_opr = (m_opr == 2) ? 5 : 2;
          else if (k == 11) m_opr = 1;
          else if (k == 12) m_opr = (m_opr == 3) ? 4 : 3;
          else if (dig || k == 14) begin
            m_mag = 0; m_sgn = 0; m_cnt = 0; m_lock = 0; m_st = M_OP2; used = 0;
          end
        end
        M_RES: begin
          if (dig || k == 12 || k == 14) m_st = M_IDLE;
          else if (k == 10 || k == 11) begin m_op1 = m_ans; m_opr = 0; m_st = M_OPR; end
          else begin used = 1; if (k == 13) m_st = M_IDLE; end
        end
        default: begin used = 1; if (k == 13) m_st = M_IDLE; end
      endcase
    end
  endtask

  function automatic int m_mode();
    case (m_st)
      M_IDLE:       return 4;
      M_OP1, M_OP2: return m_lock ? 2 : 0;
      M_OPR:        return 1;
      M_ERR:        return 3;
      default:      return 0;
    endcase
  endfunction

  function automatic int m_dval();
    case (m_st)
      M_OP1, M_OP2: return mval();
      M_OPR:        return m_opr;
      M_RES:        return m_ans;
      default:      return 0;
    endcase
  endfunction

  task automatic push_key(input int k);
    @(negedge sw_clk);
    key_valid = 1'b1;
    key_code  = 4'(k);
    model_key(k);
    @(negedge sw_clk);
    key_valid = 1'b0;
  endtask

  task automatic push_seq(input int ks[$]);
    foreach (ks[i]) begin
      push_key(ks[i]);
      @(negedge sw_clk);
    end
  endtask

  task automatic chk_disp(input string tag);
    repeat (12) @(negedge sw_clk);
    chk({tag, "_mode"}, disp_mode, m_mode());
    if (m_st != M_ERR) chk({tag, "_val"}, $signed(disp_value), m_dval());
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_start"}, calc_start, 0);
    chk({tag, "_op1"}, operand1, 0);
    chk({tag, "_op2"}, operand2, 0);
    chk({tag, "_opr"}, operator, 0);
    chk({tag, "_dval"}, disp_value, 0);
    chk({tag, "_dmode"}, disp_mode, 4);
    chk({tag, "_ovf"}, fifo_ovf, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge sw_clk);
    model_reset();
    rst = 1'b1;
    @(negedge sw_clk);
  endtask

  // Arithmetic-unit stand-in: checks each launch and answers with the model's result
  initial begin
    txn_t t;
    calc_done = 1'b0; calc_err = 1'b0; calc_ans = '0;
    forever begin
      @(negedge sw_clk);
      if (calc_start) begin
        chk("start_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          t = exp_q.pop_front();
          chk("calc_op1", $signed(operand1), t.a);
          chk("calc_op2", $signed(operand2), t.b);
          chk("calc_opr", operator, t.op);
          while (hold) @(negedge sw_clk);
          repeat ($urandom_range(0, 3)) @(negedge sw_clk);
          calc_done = 1'b1;
          calc_err  = t.err;
          calc_ans  = WIDTH'(t.r);
          @(negedge sw_clk);
          calc_done = 1'b0;
          calc_err  = 1'b0;
        end
      end
    end
  end

  initial begin
    int k, r;
    rst = 1'b0; key_valid = 1'b0; key_code = '0;
    model_reset();
    repeat (2) @(negedge sw_clk);
    chk_reset("rst");
    rst = 1'b1;
    @(negedge sw_clk);

    push_seq('{1, 2, 11, 3, 15});
    chk_disp("t1");
    chk("t1_ans", $signed(disp_value), 36);

    push_seq('{9, 9, 9, 9, 9, 9, 9, 15});
    chk_disp("t3a");
    chk("t3_pos_cap", $signed(disp_value), 999999);
    push_seq('{12, 9, 9, 9, 9, 9, 9, 9});
    chk_disp("t3b");
    chk("t3_neg_cap", $signed(disp_value), -99999);

    push_seq('{13, 1, 10, 10, 0, 15});
    chk_disp("t4a");
    chk("t4_err_mode", disp_mode, 3);
    push_seq('{7});
    chk_disp("t4b");
    push_seq('{13});
    chk_disp("t4c");
    chk("t4_blank", disp_mode, 4);

    push_seq('{12, 5, 12, 12, 2, 15});
    chk_disp("t2");

    push_seq('{13, 2, 11, 3, 11, 4, 15});
    chk_disp("t6");
    chk("t6_ans", $signed(disp_value), CHAIN ? 24 : 68);

    // Hold the arithmetic unit so the FIFO fills while waiting in the calculation
    hold = 1'b1;
    push_seq('{1, 11, 3, 15});
    repeat (10) @(negedge sw_clk);
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      k = (i == 0 || i == FIFO_DEPTH - 2) ? 13 : (i % 9) + 1;
      key_valid = 1'b1;
      key_code  = 4'(k);
      if (i < FIFO_DEPTH) model_key(k);
      @(negedge sw_clk);
    end
    key_valid = 1'b0;
    @(negedge sw_clk);
    chk("ovf_set", fifo_ovf, 1);
    hold = 1'b0;
    chk_disp("ovf_drain");

    do_reset();
    chk_reset("rst2");

    // Reset while waiting for the answer; the late done must be ignored
    hold = 1'b1;
    push_seq('{4, 11, 5, 15});
    repeat (10) @(negedge sw_clk);
    rst = 1'b0;
    repeat (2) @(negedge sw_clk);
    model_reset();
    rst  = 1'b1;
    hold = 1'b0;
    repeat (10) @(negedge sw_clk);
    chk_reset("abandon");

    rand_err = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      k = $urandom_range(0, 9);
      else if (r < 55) k = 10;
      else if (r < 63) k = 11;
      else if (r < 75) k = 12;
      else if (r < 80) k = 13;
      else if (r < 85) k = 14;
      else             k = 15;
      push_key(k);
      repeat ($urandom_range(0, 3)) @(negedge sw_clk);
      if (n % 25 == 24) chk_disp("rnd");
    end
    chk_disp("rnd_end");
    chk("starts_all_seen", exp_q.size(), 0);
    chk("rnd_no_ovf", fifo_ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
